uart_fifo_core: RTL and testbench
=================================

// Module: uart_fifo_core
// PURPOSE
//  Full-duplex UART with independent RX and TX FIFOs and valid/ready byte interfaces.
//  Runtime-programmable baud divisor; sticky frame-error and overrun flags.
//  Sits between the board rx/tx pins (ESP32 link) and on-chip logic.
//  Generalises the fixed-baud, single-shared-FIFO loopback UART top.
// PARAMETERS
//  DATA_BITS   8   bits per frame payload, LSB first
//  OVERSAMPLE  16  baud ticks per bit; must be even and >= 8
//  DIV_BITS    16  width of baud_div
//  FIFO_EXP    4   log2 depth of each FIFO (depth 16)
// PORTS
//  clk_50MHz      in   1           system clock
//  reset          in   1           synchronous, active-high
//  rx             in   1           serial input, asynchronous to clk_50MHz
//  tx             out  1           serial output, idle high
//  baud_div       in   DIV_BITS    clocks per baud tick (326 -> 9600 baud at 50 MHz)
//  parity_odd     in   1           0 = even parity, 1 = odd parity (used only with UART_PARITY_EN)
//  tx_data        in   DATA_BITS   byte to send
//  tx_valid       in   1           tx_data is valid
//  tx_ready       out  1           TX FIFO not full
//  rx_data        out  DATA_BITS   head of RX FIFO (first-word fall-through)
//  rx_valid       out  1           RX FIFO not empty
//  rx_ready       in   1           consumer accepts rx_data
//  rx_frame_err   out  1           sticky: bad stop bit or bad parity
//  rx_overrun     out  1           sticky: byte received while RX FIFO full
//  err_clr        in   1           clears both sticky flags
//  tx_idle        out  1           TX FIFO empty and TX FSM idle
//  rx_count       out  FIFO_EXP+1  RX FIFO occupancy, 0..2^FIFO_EXP
//  tx_count       out  FIFO_EXP+1  TX FIFO occupancy
// BEHAVIOUR
//  Reset (synchronous): tx=1, tx_ready=1, rx_valid=0, flags=0, counts=0, tx_idle=1, FSMs IDLE,
//   baud counter=0. Reset mid-frame aborts the frame: tx goes high the cycle after reset is sampled.
//  Baud gen: counts 0..baud_div-1; 1-cycle tick at baud_div-1. baud_div==0 stops ticks (UART frozen).
//   baud_div is re-read at every wrap; a change takes effect at the next tick period.
//  RX sync: 2-flop synchroniser on rx; the FSM sees the synchronised signal only.
//  RX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE.
//   IDLE: falling edge -> START, tick count=0.
//   START: at tick OVERSAMPLE/2-1, if line still low -> DATA, else glitch -> IDLE, no flag.
//   DATA/PARITY/STOP: sample at every OVERSAMPLE ticks (mid-bit).
//   STOP sampled 0 -> byte discarded, rx_frame_err set, wait for line high before IDLE.
//   Good frame: pushed into RX FIFO; rx_valid rises the cycle after the stop-sample tick.
//   RX FIFO full at push: byte dropped, rx_overrun set, FIFO contents untouched.
//  RX pop on rx_valid&&rx_ready; next head is visible on the following cycle.
//  TX push on tx_valid&&tx_ready. TX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE.
//   Each bit lasts OVERSAMPLE ticks; stop is 1 bit.
//   IDLE with FIFO non-empty: pop the head, drive tx=0 on the next cycle.
//   Back-to-back bytes: no idle gap beyond 1 clock.
//  Each FIFO does circular addressing; pointers wrap at 2^FIFO_EXP.
//   Simultaneous push and pop: allowed when neither full (push) nor empty (pop) blocks; count unchanged.
//   Push on full is ignored (tx_ready=0 already); pop on empty is ignored.
//  Sticky flags: a set event in the same cycle as err_clr wins (flag stays 1).
// CONFIGURATION
//  UART_PARITY_EN defined:
//   PARITY state present. TX sends a parity bit per parity_odd.
//   An RX parity mismatch discards the byte and sets rx_frame_err.
//  UART_PARITY_EN undefined:
//   No parity bit; parity_odd is ignored. Frame = 1 start + DATA_BITS + 1 stop.
// TESTING (baud_div=4, OVERSAMPLE=16 -> 64 clocks/bit)
//  Reset: hold reset 3 cycles -> tx=1, tx_ready=1, rx_valid=0, counts 0, flags 0.
//  Push 0xA5 then 0x3C -> tx shows 0,1,0,1,0,0,1,0,1,1 (LSB first) then 0x3C frame with no gap;
//   tx_idle=1 after the stop bit.
//  Drive rx frame 0x5A -> rx_valid=1, rx_data=0x5A, rx_count=1; rx_ready 1 cycle -> rx_valid=0.
//  Send 17 bytes with rx_ready=0 -> rx_count=16, rx_overrun=1, head still byte 1;
//   err_clr -> flag 0.
//  rx frame with stop bit 0 -> rx_frame_err=1, rx_count unchanged.
//   Start glitch of 20 clocks -> no byte, no flag.
//  UART_PARITY_EN, parity_odd=0: TX 0x07 -> parity bit 1.
//   RX 0x07 with parity 0 -> rx_frame_err=1, byte dropped.

Source files
------------

// File: rtl/uart_fifo_core.sv
`timescale 1ns/1ps
// uart_fifo_core
//   Full-duplex UART: serial rx/tx pins on one side, valid/ready byte streams
//   on the other, each direction buffered by its own FIFO. Baud rate comes from
//   a runtime divisor; frame errors and RX overruns are latched as sticky flags.
//
// Optional feature macro: UART_PARITY_EN (adds one parity bit per frame,
//   even/odd selected by parity_odd; RX parity mismatch counts as frame error).
//
// Ports
//   clk_50MHz, reset       system clock, synchronous active-high reset
//   rx / tx                serial input (async, synchronised) / serial output
//   baud_div               clocks per baud tick, 0 freezes the UART
//   parity_odd             parity sense (parity build only)
//   tx_data/valid/ready    byte stream into the TX FIFO
//   rx_data/valid/ready    first-word-fall-through head of the RX FIFO
//   rx_frame_err, rx_overrun  sticky flags, cleared by err_clr
//   tx_idle                nothing queued and transmitter idle
//   rx_count, tx_count     FIFO occupancies

// Small synchronous FIFO with registered read. The output register is
// preloaded with the entry at the next read pointer, so the head is always
// presented without an explicit read request.
module uart_fifo_core_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);
    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [W-1:0]  rd_data_reg;
    logic          do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_ptr_next = rd_ptr_reg + AW'(do_pop);
    assign count   = count_reg;
    assign rd_data = rd_data_reg;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_next;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
            // The slot being written is the next head only when the FIFO is
            // (about to be) empty; bypass the RAM in that case.
            if (do_push && (wr_ptr_reg == rd_ptr_next))
                rd_data_reg <= wr_data;
            else
                rd_data_reg <= mem[rd_ptr_next];
        end
    end
endmodule

module uart_fifo_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_BITS   = 16,
    parameter int FIFO_EXP   = 4
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DIV_BITS-1:0]  baud_div,
    input  logic                 parity_odd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    input  logic                 err_clr,
    output logic                 tx_idle,
    output logic [FIFO_EXP:0]    rx_count,
    output logic [FIFO_EXP:0]    tx_count
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;   // RX only: line held low after bad stop

    // ---------------- baud tick generator ----------------
    // The divisor is latched at each wrap so a change never truncates the
    // period in progress; a zero divisor keeps reloading and never ticks.
    logic [DIV_BITS-1:0] baud_cnt_reg, div_reg;
    logic                baud_tick;

    assign baud_tick = (div_reg != '0) && (baud_cnt_reg == div_reg - DIV_BITS'(1));

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            baud_cnt_reg <= '0;
            div_reg      <= baud_div;
        end else if (div_reg == '0 || baud_tick) begin
            baud_cnt_reg <= '0;
            div_reg      <= baud_div;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + DIV_BITS'(1);
        end
    end

    // ---------------- FIFOs ----------------
    logic                 rx_push, rx_full, rx_empty;
    logic                 tx_load, tx_full, tx_empty;
    logic [DATA_BITS-1:0] tx_head;
    logic [DATA_BITS-1:0] rx_shift_reg;

    uart_fifo_core_fifo #(.W(DATA_BITS), .AW(FIFO_EXP)) u_rx_fifo (
        .clk(clk_50MHz), .srst(reset),
        .wr_en(rx_push), .wr_data(rx_shift_reg),
        .rd_en(rx_ready), .rd_data(rx_data),
        .empty(rx_empty), .full(rx_full), .count(rx_count)
    );

    uart_fifo_core_fifo #(.W(DATA_BITS), .AW(FIFO_EXP)) u_tx_fifo (
        .clk(clk_50MHz), .srst(reset),
        .wr_en(tx_valid), .wr_data(tx_data),
        .rd_en(tx_load), .rd_data(tx_head),
        .empty(tx_empty), .full(tx_full), .count(tx_count)
    );

    assign rx_valid = !rx_empty;
    assign tx_ready = !tx_full;

    // ---------------- RX path ----------------
    logic [1:0]        rx_sync_reg;
    logic              rx_s, rx_prev_reg;
    logic [2:0]        rx_state_reg;
    logic [TICK_W-1:0] rx_tick_reg;
    logic [BIT_W-1:0]  rx_bit_reg;
    logic              rx_par_err_reg;
    logic              rx_sample, rx_stop_sample, rx_err_set, rx_ovr_set;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rx_sync
            always_ff @(posedge clk_50MHz) begin
                if (reset)
                    rx_sync_reg[gi] <= 1'b1;
                else
                    rx_sync_reg[gi] <= (gi == 0) ? rx : rx_sync_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    endgenerate

    assign rx_s           = rx_sync_reg[1];
    assign rx_sample      = baud_tick && (rx_tick_reg == TICK_LAST);
    assign rx_stop_sample = (rx_state_reg == ST_STOP) && rx_sample;
    assign rx_push        = rx_stop_sample && rx_s && !rx_par_err_reg;
    assign rx_err_set     = rx_stop_sample && (!rx_s || rx_par_err_reg);
    assign rx_ovr_set     = rx_push && rx_full;

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            rx_prev_reg    <= 1'b1;
            rx_state_reg   <= ST_IDLE;
            rx_tick_reg    <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_par_err_reg <= 1'b0;
        end else begin
            rx_prev_reg <= rx_s;
            case (rx_state_reg)
                ST_IDLE: begin
                    if (rx_prev_reg && !rx_s) begin
                        rx_state_reg <= ST_START;
                        rx_tick_reg  <= '0;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        if (rx_tick_reg == TICK_HALF) begin
                            // Re-check at mid start bit; a short low pulse is ignored.
                            rx_state_reg   <= rx_s ? ST_IDLE : ST_DATA;
                            rx_tick_reg    <= '0;
                            rx_bit_reg     <= '0;
                            rx_par_err_reg <= 1'b0;
                        end else begin
                            rx_tick_reg <= rx_tick_reg + TICK_W'(1);
                        end
                    end
                end
                ST_DATA, ST_PARITY, ST_STOP: begin
                    if (baud_tick) begin
                        if (rx_tick_reg == TICK_LAST) begin
                            rx_tick_reg <= '0;
                            if (rx_state_reg == ST_DATA) begin
                                rx_shift_reg <= {rx_s, rx_shift_reg[DATA_BITS-1:1]};
                                if (rx_bit_reg == BIT_LAST) begin
`ifdef UART_PARITY_EN
                                    rx_state_reg <= ST_PARITY;
`else
                                    rx_state_reg <= ST_STOP;
`endif
                                end else begin
                                    rx_bit_reg <= rx_bit_reg + BIT_W'(1);
                                end
                            end else if (rx_state_reg == ST_PARITY) begin
                                rx_par_err_reg <= (rx_s != ((^rx_shift_reg) ^ parity_odd));
                                rx_state_reg   <= ST_STOP;
                            end else begin
                                rx_state_reg <= rx_s ? ST_IDLE : ST_WAIT;
                            end
                        end else begin
                            rx_tick_reg <= rx_tick_reg + TICK_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (rx_s)
                        rx_state_reg <= ST_IDLE;
                end
                default: rx_state_reg <= ST_IDLE;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as err_clr keeps the flag high.
    logic rx_frame_err_reg, rx_overrun_reg;
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            rx_frame_err_reg <= 1'b0;
            rx_overrun_reg   <= 1'b0;
        end else begin
            rx_frame_err_reg <= rx_err_set | (rx_frame_err_reg & ~err_clr);
            rx_overrun_reg   <= rx_ovr_set | (rx_overrun_reg & ~err_clr);
        end
    end
    assign rx_frame_err = rx_frame_err_reg;
    assign rx_overrun   = rx_overrun_reg;

    // ---------------- TX path ----------------
    logic [2:0]           tx_state_reg;
    logic [TICK_W-1:0]    tx_tick_reg;
    logic [BIT_W-1:0]     tx_bit_reg;
    logic [DATA_BITS-1:0] tx_shift_reg;
    logic                 tx_reg, tx_bit_end;

    assign tx_bit_end = baud_tick && (tx_tick_reg == TICK_LAST);
    // Load from IDLE, or straight out of the stop bit so bytes go back to back.
    assign tx_load = !tx_empty &&
                     ((tx_state_reg == ST_IDLE) || ((tx_state_reg == ST_STOP) && tx_bit_end));

`ifdef UART_PARITY_EN
    logic tx_par_reg;
    always_ff @(posedge clk_50MHz) begin
        if (reset)
            tx_par_reg <= 1'b0;
        else if (tx_load)
            tx_par_reg <= (^tx_head) ^ parity_odd;
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            tx_state_reg <= ST_IDLE;
            tx_tick_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_reg       <= 1'b1;
        end else if (tx_load) begin
            tx_shift_reg <= tx_head;
            tx_reg       <= 1'b0;
            tx_state_reg <= ST_START;
            tx_tick_reg  <= '0;
        end else if (tx_state_reg != ST_IDLE && baud_tick) begin
            if (tx_tick_reg == TICK_LAST) begin
                tx_tick_reg <= '0;
                case (tx_state_reg)
                    ST_START: begin
                        tx_reg       <= tx_shift_reg[0];
                        tx_bit_reg   <= '0;
                        tx_state_reg <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (tx_bit_reg == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            tx_reg       <= tx_par_reg;
                            tx_state_reg <= ST_PARITY;
`else
                            tx_reg       <= 1'b1;
                            tx_state_reg <= ST_STOP;
`endif
                        end else begin
                            tx_reg       <= tx_shift_reg[1];
                            tx_shift_reg <= tx_shift_reg >> 1;
                            tx_bit_reg   <= tx_bit_reg + BIT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        tx_reg       <= 1'b1;
                        tx_state_reg <= ST_STOP;
                    end
                    default: begin
                        tx_reg       <= 1'b1;
                        tx_state_reg <= ST_IDLE;
                    end
                endcase
            end else begin
                tx_tick_reg <= tx_tick_reg + TICK_W'(1);
            end
        end
    end

    assign tx      = tx_reg;
    assign tx_idle = tx_empty && (tx_state_reg == ST_IDLE);
endmodule

// File: tb/tb_uart_fifo_core.sv
`timescale 1ns/1ps
module tb_uart_fifo_core;
    localparam int BIT_CLKS = 64;   // baud_div=4, OVERSAMPLE=16
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        reset, rx, tx, parity_odd, tx_valid, tx_ready;
    logic        rx_valid, rx_ready, rx_frame_err, rx_overrun, err_clr, tx_idle;
    logic [15:0] baud_div;
    logic [7:0]  tx_data, rx_data;
    logic [4:0]  rx_count, tx_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    always #10 clk = ~clk;

    uart_fifo_core dut (
        .clk_50MHz(clk), .reset(reset), .rx(rx), .tx(tx), .baud_div(baud_div),
        .parity_odd(parity_odd), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
        .err_clr(err_clr), .tx_idle(tx_idle), .rx_count(rx_count), .tx_count(tx_count)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Expected serial frame, index 0 = start bit.
    function automatic logic [NB-1:0] exp_frame(input logic [7:0] d);
`ifdef UART_PARITY_EN
        return {1'b1, (^d) ^ parity_odd, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    // Drive one frame onto rx, LSB first.
    task automatic send_rx(input logic [7:0] b, input logic stop_b, input logic par_flip);
        $display("rx frame %02h stop %0d parity_flip %0d", b, stop_b, par_flip);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx = (^b) ^ parity_odd ^ par_flip;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        rx = stop_b;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
    endtask

    // Wait (bounded) for a start bit on tx and sample every bit at mid-bit.
    // Returns at the middle of the stop bit.
    task automatic capture_tx(input int budget, output logic [NB-1:0] frame, output bit found);
        found = 1'b0;
        frame = '0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
        if (found) begin
            repeat (BIT_CLKS / 2) @(negedge clk);
            frame[0] = tx;
            for (int k = 1; k < NB; k++) begin
                repeat (BIT_CLKS) @(negedge clk);
                frame[k] = tx;
            end
            $display("tx frame captured %b", frame);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        tx_exp_q.push_back(b);
        $display("tx push %02h", b);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; baud_div = 16'd4; parity_odd = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks += 8;
        if (tx !== 1'b1)         begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        if (tx_ready !== 1'b1)   begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
        if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        if (rx_count !== 5'd0)   begin errors++; $display("FAIL reset_rx_count got %0d want 0", rx_count); end
        if (tx_count !== 5'd0)   begin errors++; $display("FAIL reset_tx_count got %0d want 0", tx_count); end
        if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", rx_frame_err); end
        if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", rx_overrun); end
        if (tx_idle !== 1'b1)    begin errors++; $display("FAIL reset_tx_idle got %b want 1", tx_idle); end
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] frame, want;
        bit found;
        logic [7:0] exp_b;
        push_tx(8'hA5);
        push_tx(8'h3C);
        @(negedge clk);
        tx_valid = 1'b0;
        for (int f = 0; f < 2; f++) begin
            // Second frame must start right after the first stop bit.
            capture_tx((f == 0) ? 200 : 40, frame, found);
            checks++;
            if (!found) begin
                errors++; $display("FAIL tx_start_%0d got no start bit want start", f);
            end else begin
                exp_b = tx_exp_q.pop_front();
                want  = exp_frame(exp_b);
                checks++;
                if (frame !== want) begin
                    errors++; $display("FAIL tx_frame_%0d got %b want %b", f, frame, want);
                end
                checks++;
                if (tx_idle !== 1'b0) begin
                    errors++; $display("FAIL tx_idle_busy_%0d got %b want 0", f, tx_idle);
                end
            end
        end
        begin
            bit idle_seen = 1'b0;
            for (int n = 0; n < 80 && !idle_seen; n++) begin
                @(negedge clk);
                if (tx_idle === 1'b1) idle_seen = 1'b1;
            end
            checks += 2;
            if (!idle_seen) begin errors++; $display("FAIL tx_idle_end got 0 want 1"); end
            if (tx !== 1'b1) begin errors++; $display("FAIL tx_line_idle got %b want 1", tx); end
        end
    endtask

    task automatic test_reset_mid_frame();
        push_tx(8'h00);
        @(negedge clk);
        tx_valid = 1'b0;
        void'(tx_exp_q.pop_back());     // this byte is aborted, never checked on the line
        repeat (3 * BIT_CLKS) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL abort_pre_tx got %b want 0", tx); end
        reset = 1'b1;
        @(negedge clk);
        checks += 2;
        if (tx !== 1'b1)      begin errors++; $display("FAIL abort_tx got %b want 1", tx); end
        if (tx_idle !== 1'b1) begin errors++; $display("FAIL abort_tx_idle got %b want 1", tx_idle); end
        reset = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL abort_stays_idle got %b want 1", tx); end
    endtask

    task automatic test_rx_single();
        rx_exp_q.push_back(8'h5A);
        send_rx(8'h5A, 1'b1, 1'b0);
        @(negedge clk);
        checks += 3;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL rx_valid got %b want 1", rx_valid); end
        if (rx_count !== 5'd1) begin errors++; $display("FAIL rx_count got %0d want 1", rx_count); end
        if (rx_data !== rx_exp_q.pop_front()) begin errors++; $display("FAIL rx_data got %02h want 5a", rx_data); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks += 2;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pop_valid got %b want 0", rx_valid); end
        if (rx_count !== 5'd0) begin errors++; $display("FAIL rx_pop_count got %0d want 0", rx_count); end
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        logic [7:0] exp_b;
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 37 + 11);
            if (i < 16) rx_exp_q.push_back(b);
            send_rx(b, 1'b1, 1'b0);
        end
        @(negedge clk);
        checks += 4;
        if (rx_count !== 5'd16)  begin errors++; $display("FAIL ovr_count got %0d want 16", rx_count); end
        if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", rx_overrun); end
        if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL ovr_frame_err got %b want 0", rx_frame_err); end
        if (rx_data !== rx_exp_q[0]) begin errors++; $display("FAIL ovr_head got %02h want %02h", rx_data, rx_exp_q[0]); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", rx_overrun); end
        for (int k = 0; k < 16; k++) begin
            exp_b = rx_exp_q.pop_front();
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
                errors++; $display("FAIL drain_%0d got valid %b data %02h want valid 1 data %02h", k, rx_valid, rx_data, exp_b);
            end
            rx_ready = 1'b1;
            @(negedge clk);
        end
        rx_ready = 1'b0;
        checks++;
        if (rx_count !== 5'd0) begin errors++; $display("FAIL drain_count got %0d want 0", rx_count); end
    endtask

    task automatic test_frame_err();
        send_rx(8'h33, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checks += 2;
        if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", rx_frame_err); end
        if (rx_count !== 5'd0)     begin errors++; $display("FAIL ferr_count got %0d want 0", rx_count); end
        rx_exp_q.push_back(8'hC3);
        send_rx(8'hC3, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== rx_exp_q[0]) begin
            errors++; $display("FAIL ferr_recover got valid %b data %02h want valid 1 data %02h", rx_valid, rx_data, rx_exp_q[0]);
        end
        void'(rx_exp_q.pop_front());
        rx_ready = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0; err_clr = 1'b0;
        checks++;
        if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b want 0", rx_frame_err); end
    endtask

    task automatic test_glitch();
        $display("rx glitch 20 clocks");
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (11 * BIT_CLKS) @(negedge clk);
        checks += 2;
        if (rx_valid !== 1'b0)     begin errors++; $display("FAIL glitch_valid got %b want 0", rx_valid); end
        if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL glitch_flag got %b want 0", rx_frame_err); end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic [NB-1:0] frame;
        bit found;
        parity_odd = 1'b0;
        push_tx(8'h07);
        @(negedge clk);
        tx_valid = 1'b0;
        capture_tx(200, frame, found);
        void'(tx_exp_q.pop_front());
        checks++;
        if (!found || frame[9] !== 1'b1) begin
            errors++; $display("FAIL par_tx_bit got found %0d bit %b want 1", found, frame[9]);
        end
        repeat (BIT_CLKS) @(negedge clk);
        send_rx(8'h07, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        checks += 2;
        if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL par_rx_flag got %b want 1", rx_frame_err); end
        if (rx_count !== 5'd0)     begin errors++; $display("FAIL par_rx_count got %0d want 0", rx_count); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_reset_mid_frame();
        test_rx_single();
        test_overrun();
        test_frame_err();
        test_glitch();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
